arp_static_resolver: RTL and testbench

Responder end of the ARP request/response interface consumed by the IPv4 transmit block. Accepts a destination IP on the request channel and resolves it to a next-hop MAC using subnet/gateway rules and a software-programmed table of `ENTRIES` IP→MAC pairs, scanned one entry per cycle. It returns the MAC, or an error on a miss, on the response channel. It replaces the fixed destination MAC in the transmit path and sits beside the IP block in the 64-bit UDP/IP stack.

---
 rtl/arp_static_resolver.sv | 166 ++++++++++++++++
 tb/tb_arp_static_resolver.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_static_resolver.sv
// arp_static_resolver
// Resolves a destination IPv4 address to a next-hop MAC. Broadcast addresses
// resolve immediately; all others are looked up (directly or via the gateway)
// in a software-written table scanned one entry per cycle, lowest index first.
module arp_static_resolver #(
    parameter int ENTRIES = 8,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arp_request_valid,
    output logic          arp_request_ready,
    input  logic [31:0]   arp_request_ip,
    output logic          arp_response_valid,
    input  logic          arp_response_ready,
    output logic          arp_response_error,
    output logic [47:0]   arp_response_mac,
    input  logic          cfg_wr_en,
    input  logic [IW-1:0] cfg_wr_index,
    input  logic          cfg_wr_valid,
    input  logic [31:0]   cfg_wr_ip,
    input  logic [47:0]   cfg_wr_mac,
    input  logic          cache_clear,
    input  logic [31:0]   local_ip,
    input  logic [31:0]   gateway_ip,
    input  logic [31:0]   subnet_mask,
    output logic          busy,
    output logic [15:0]   miss_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [31:0]   target_reg, target_next;
    logic [47:0]   mac_reg, mac_next;
    logic          err_reg, err_next;
    logic [15:0]   miss_count_reg, miss_count_next;
    logic          ready_reg;
    logic          resp_valid_reg;
    logic          busy_reg;

    // Table: valid bits are resettable, IP/MAC storage is not.
    logic          valid_bits_reg [ENTRIES];
    logic [31:0]   tbl_ip         [ENTRIES];
    logic [47:0]   tbl_mac        [ENTRIES];

    logic accept;
    logic on_subnet;
    logic is_bcast;
    logic entry_hit;
    logic last_entry;

    assign accept     = arp_request_valid && ready_reg && (state_reg == IDLE);
    assign on_subnet  = ((arp_request_ip ^ local_ip) & subnet_mask) == 32'h0;
    assign is_bcast   = (arp_request_ip == 32'hFFFF_FFFF) ||
                        (on_subnet && ((arp_request_ip | subnet_mask) == 32'hFFFF_FFFF));
    // Compare sees pre-write contents when a write to the same entry lands this edge.
    assign entry_hit  = valid_bits_reg[idx_reg] && (tbl_ip[idx_reg] == target_reg);
    assign last_entry = (idx_reg == IW'(ENTRIES - 1));

    // Per-entry valid bit: clear beats a same-cycle write to the entry.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst || cache_clear) begin
                    valid_bits_reg[gi] <= 1'b0;
                end else if (cfg_wr_en && (cfg_wr_index == IW'(gi))) begin
                    valid_bits_reg[gi] <= cfg_wr_valid;
                end
            end
        end
    endgenerate

    // Table IP/MAC storage: written in any state, never cleared.
    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            tbl_ip[cfg_wr_index]  <= cfg_wr_ip;
            tbl_mac[cfg_wr_index] <= cfg_wr_mac;
        end
    end

    // State and datapath registers; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            target_reg     <= '0;
            mac_reg        <= '0;
            err_reg        <= 1'b0;
            miss_count_reg <= '0;
            ready_reg      <= 1'b0;
            resp_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            target_reg     <= target_next;
            mac_reg        <= mac_next;
            err_reg        <= err_next;
            miss_count_reg <= miss_count_next;
            ready_reg      <= (state_next == IDLE);
            resp_valid_reg <= (state_next == RESP);
            busy_reg       <= (state_next != IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = is_bcast ? RESP : SEARCH;
            SEARCH:  if (entry_hit || last_entry) state_next = RESP;
            RESP:    if (arp_response_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values: classification, scan index, result and miss counter.
    always_comb begin
        idx_next        = idx_reg;
        target_next     = target_reg;
        mac_next        = mac_reg;
        err_next        = err_reg;
        miss_count_next = miss_count_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    idx_next    = '0;
                    target_next = on_subnet ? arp_request_ip : gateway_ip;
                    if (is_bcast) begin
                        mac_next = 48'hFFFF_FFFF_FFFF;
                        err_next = 1'b0;
                    end
                end
            end
            SEARCH: begin
                if (entry_hit) begin
                    mac_next = tbl_mac[idx_reg];
                    err_next = 1'b0;
                end else if (last_entry) begin
                    mac_next = '0;
                    err_next = 1'b1;
                    if (miss_count_reg != 16'hFFFF) begin
                        miss_count_next = miss_count_reg + 16'd1;
                    end
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            default: ;
        endcase
    end

    assign arp_request_ready  = ready_reg;
    assign arp_response_valid = resp_valid_reg;
    assign arp_response_error = err_reg;
    assign arp_response_mac   = mac_reg;
    assign busy               = busy_reg;
    assign miss_count         = miss_count_reg;

endmodule

// File: tb/tb_arp_static_resolver.sv
// tb_arp_static_resolver
// Directed scenarios followed by randomized traffic, each request checked
// against a table-level reference model of the resolver.
module tb_arp_static_resolver;

    localparam int ENTRIES = 8;
    localparam int IW      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arp_request_valid = 1'b0;
    logic          arp_request_ready;
    logic [31:0]   arp_request_ip = '0;
    logic          arp_response_valid;
    logic          arp_response_ready = 1'b0;
    logic          arp_response_error;
    logic [47:0]   arp_response_mac;
    logic          cfg_wr_en = 1'b0;
    logic [IW-1:0] cfg_wr_index = '0;
    logic          cfg_wr_valid = 1'b0;
    logic [31:0]   cfg_wr_ip = '0;
    logic [47:0]   cfg_wr_mac = '0;
    logic          cache_clear = 1'b0;
    logic [31:0]   local_ip = 32'h0A00_0005;
    logic [31:0]   gateway_ip = 32'h0A00_0001;
    logic [31:0]   subnet_mask = 32'hFFFF_FF00;
    logic          busy;
    logic [15:0]   miss_count;

    always #5 clk = ~clk;

    arp_static_resolver #(.ENTRIES(ENTRIES)) dut (
        .clk                (clk),
        .rst                (rst),
        .arp_request_valid  (arp_request_valid),
        .arp_request_ready  (arp_request_ready),
        .arp_request_ip     (arp_request_ip),
        .arp_response_valid (arp_response_valid),
        .arp_response_ready (arp_response_ready),
        .arp_response_error (arp_response_error),
        .arp_response_mac   (arp_response_mac),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_wr_index       (cfg_wr_index),
        .cfg_wr_valid       (cfg_wr_valid),
        .cfg_wr_ip          (cfg_wr_ip),
        .cfg_wr_mac         (cfg_wr_mac),
        .cache_clear        (cache_clear),
        .local_ip           (local_ip),
        .gateway_ip         (gateway_ip),
        .subnet_mask        (subnet_mask),
        .busy               (busy),
        .miss_count         (miss_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the table contents and the miss counter.
    logic        m_valid [ENTRIES];
    logic [31:0] m_ip    [ENTRIES];
    logic [47:0] m_mac   [ENTRIES];
    int          m_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected result and latency of a lookup against the current model.
    function automatic void predict(input logic [31:0] ip, output logic [47:0] mac,
                                    output logic err, output int lat);
        logic [31:0] tgt;
        bit          same_net;
        same_net = ((ip ^ local_ip) & subnet_mask) == 32'h0;
        if (ip == 32'hFFFF_FFFF || (same_net && (ip | subnet_mask) == 32'hFFFF_FFFF)) begin
            mac = 48'hFFFF_FFFF_FFFF;
            err = 1'b0;
            lat = 1;
            return;
        end
        tgt = same_net ? ip : gateway_ip;
        for (int k = 0; k < ENTRIES; k++) begin
            if (m_valid[k] && m_ip[k] == tgt) begin
                mac = m_mac[k];
                err = 1'b0;
                lat = k + 2;
                return;
            end
        end
        mac = '0;
        err = 1'b1;
        lat = ENTRIES + 1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
    endtask

    task automatic tbl_write(input int idx, input bit v, input logic [31:0] ip,
                             input logic [47:0] mac, input bit clr);
        @(negedge clk);
        cfg_wr_en    = 1'b1;
        cfg_wr_index = IW'(idx);
        cfg_wr_valid = v;
        cfg_wr_ip    = ip;
        cfg_wr_mac   = mac;
        cache_clear  = clr;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
        cache_clear = 1'b0;
        if (clr) model_clear();
        m_valid[idx] = v && !clr;
        m_ip[idx]    = ip;
        m_mac[idx]   = mac;
    endtask

    task automatic clear_only();
        @(negedge clk);
        cache_clear = 1'b1;
        @(negedge clk);
        cache_clear = 1'b0;
        model_clear();
    endtask

    // One request transaction. stall: cycles to hold response_ready low.
    // cidx >= 0: write that entry invalid during the cycle it is compared.
    task automatic do_request(input logic [31:0] ip, input int stall, input int cidx,
                              input string tag);
        logic [47:0] emac;
        logic        eerr;
        int          elat;
        int          n;
        predict(ip, emac, eerr, elat);
        @(negedge clk);
        n = 0;
        while (!arp_request_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s req_ready", tag), 64'(arp_request_ready), 64'(1));
        arp_request_valid = 1'b1;
        arp_request_ip    = ip;
        @(negedge clk);
        arp_request_valid = 1'b0;
        arp_request_ip    = $urandom;
        check($sformatf("%s ready_drop", tag), 64'(arp_request_ready), 64'(0));
        check($sformatf("%s busy", tag), 64'(busy), 64'(1));
        n = 1;
        forever begin
            cfg_wr_en = (cidx >= 0) && (n == cidx + 1);
            if (cfg_wr_en) begin
                cfg_wr_index = IW'(cidx);
                cfg_wr_valid = 1'b0;
                cfg_wr_ip    = m_ip[cidx];
                cfg_wr_mac   = m_mac[cidx];
            end
            if (arp_response_valid || n >= ENTRIES + 8) break;
            @(negedge clk);
            n++;
        end
        cfg_wr_en = 1'b0;
        if (cidx >= 0) m_valid[cidx] = 1'b0;
        if (eerr && m_miss < 65535) m_miss++;
        check($sformatf("%s latency", tag), 64'(n), 64'(elat));
        check($sformatf("%s resp_valid", tag), 64'(arp_response_valid), 64'(1));
        check($sformatf("%s mac", tag), 64'(arp_response_mac), 64'(emac));
        check($sformatf("%s error", tag), 64'(arp_response_error), 64'(eerr));
        check($sformatf("%s miss_count", tag), 64'(miss_count), 64'(m_miss));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check($sformatf("%s stall_valid", tag), 64'(arp_response_valid), 64'(1));
            check($sformatf("%s stall_mac", tag), 64'(arp_response_mac), 64'(emac));
            check($sformatf("%s stall_err", tag), 64'(arp_response_error), 64'(eerr));
            check($sformatf("%s stall_ready", tag), 64'(arp_request_ready), 64'(0));
        end
        arp_response_ready = 1'b1;
        @(negedge clk);
        arp_response_ready = 1'b0;
        check($sformatf("%s resp_drop", tag), 64'(arp_response_valid), 64'(0));
        check($sformatf("%s ready_back", tag), 64'(arp_request_ready), 64'(1));
        check($sformatf("%s idle", tag), 64'(busy), 64'(0));
        $display("txn %s: ip=%h mac=%h err=%0d latency=%0d", tag, ip, emac, eerr, elat);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s ready", tag), 64'(arp_request_ready), 64'(0));
        check($sformatf("%s resp_valid", tag), 64'(arp_response_valid), 64'(0));
        check($sformatf("%s error", tag), 64'(arp_response_error), 64'(0));
        check($sformatf("%s mac", tag), 64'(arp_response_mac), 64'(0));
        check($sformatf("%s busy", tag), 64'(busy), 64'(0));
        check($sformatf("%s miss_count", tag), 64'(miss_count), 64'(0));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [47:0] mac_a;
        logic [47:0] mac_b;
        logic [31:0] rip;
        logic [47:0] rmac;
        int          n;

        model_clear();
        for (int k = 0; k < ENTRIES; k++) begin
            m_ip[k]  = '0;
            m_mac[k] = '0;
        end

        // Reset state, then ready rises one cycle after release.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_release ready", 64'(arp_request_ready), 64'(1));

        // Broadcast forms.
        do_request(32'h0A00_00FF, 0, -1, "bcast_subnet");
        do_request(32'hFFFF_FFFF, 0, -1, "bcast_all");

        // Hit at entry 3 with a 4-cycle response stall.
        tbl_write(3, 1'b1, 32'h0A00_0007, 48'hE41D_2DB2_0808, 1'b0);
        do_request(32'h0A00_0007, 4, -1, "hit_stall");

        // Off-subnet goes through the gateway in entry 0.
        tbl_write(0, 1'b1, 32'h0A00_0001, 48'h0200_0000_0001, 1'b0);
        do_request(32'h0808_0808, 0, -1, "gateway");

        // Miss, then clear colliding with a write to entry 3.
        do_request(32'h0A00_0009, 0, -1, "miss");
        tbl_write(3, 1'b1, 32'h0A00_0007, 48'hE41D_2DB2_0808, 1'b1);
        do_request(32'h0A00_0007, 0, -1, "after_clear");

        // Duplicates: lowest index wins; write in the compare cycle sees old data.
        mac_a = 48'hAAAA_0000_0002;
        mac_b = 48'hBBBB_0000_0005;
        tbl_write(2, 1'b1, 32'h0A00_0007, mac_a, 1'b0);
        tbl_write(5, 1'b1, 32'h0A00_0007, mac_b, 1'b0);
        do_request(32'h0A00_0007, 1, -1, "dup_low");
        do_request(32'h0A00_0007, 0, 2, "wr_collide");
        do_request(32'h0A00_0007, 0, -1, "dup_next");

        // Reset during SEARCH.
        @(negedge clk);
        n = 0;
        while (!arp_request_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        arp_request_valid = 1'b1;
        arp_request_ip    = 32'h0A00_0009;
        @(negedge clk);
        arp_request_valid = 1'b0;
        @(negedge clk);
        check("mid_search busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        model_clear();
        m_miss = 0;
        @(negedge clk);
        check("mid_reset release ready", 64'(arp_request_ready), 64'(1));
        do_request(32'h0A00_0007, 0, -1, "post_reset_miss");

        // Saturation: preload the counter near its ceiling, then force misses.
        @(negedge clk);
        dut.miss_count_reg = 16'hFFFD;
        m_miss = 65533;
        for (int i = 0; i < 3; i++) begin
            do_request(32'h0A00_0009, 0, -1, $sformatf("saturate%0d", i));
        end

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    rip  = {24'h0A_0000, 4'h0, 4'($urandom_range(0, 15))};
                    rmac = {16'($urandom), 32'($urandom)};
                    tbl_write(int'($urandom_range(0, ENTRIES - 1)), ($urandom_range(0, 3) != 0),
                              rip, rmac, ($urandom_range(0, 7) == 0));
                end
                3: clear_only();
                4: begin
                    @(negedge clk);
                    subnet_mask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FF00 : 32'hFFFF_FFF0;
                end
                default: begin
                    case ($urandom_range(0, 5))
                        0:       rip = 32'hFFFF_FFFF;
                        1:       rip = (local_ip & subnet_mask) | ~subnet_mask;
                        2, 3:    rip = {24'h0A_0000, 4'h0, 4'($urandom_range(0, 15))};
                        4:       rip = {8'd8, 24'($urandom)};
                        default: rip = {24'h0A_0000, 8'($urandom)};
                    endcase
                    do_request(rip, int'($urandom_range(0, 2)), -1, $sformatf("rand%0d", it));
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
